// File: rtl/demux1xn_fc.sv
// 1-to-N demultiplexer: routes each accepted word to the downstream FIFO chosen by select; optional push counters (DEMUX_STATS_EN).
// Latency: one cycle from acceptance to the push strobe and output data; held words push one cycle after full[target] clears.
// Backpressure: a full target parks the word in a one-entry hold register and drops ready_in until that target frees up.
module demux1xn_fc #(
    parameter int DATA_W = 10,
    parameter int N_OUT  = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       in,
    input  logic                    valid_in,
    input  logic [SEL_W-1:0]        select,
    input  logic [N_OUT-1:0]        full,
    output logic                    ready_in,
    output logic [N_OUT*DATA_W-1:0] out,
    output logic [N_OUT-1:0]        push,
    output logic                    sel_err,
    output logic [N_OUT*CNT_W-1:0]  push_cnt
);

    typedef enum logic [0:0] {
        PASS  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   hold_dat_q, hold_dat_d;
    logic [SEL_W-1:0]    hold_sel_q, hold_sel_d;
    logic [DATA_W-1:0]   out_q [N_OUT];
    logic [DATA_W-1:0]   out_d [N_OUT];
    logic [N_OUT-1:0]    push_q, push_d;
    logic                sel_err_q, sel_err_d;

    // One-hot decodes of the incoming and held selects; an all-zero
    // in_oh means the select points past the last channel.
    logic [N_OUT-1:0]    in_oh;
    logic [N_OUT-1:0]    hold_oh;
    logic                in_sel_ok;
    logic                in_tgt_full;
    logic                hold_tgt_full;

    // Decode select fields and look up only the targeted channel's full flag
    always_comb begin
        in_oh   = '0;
        hold_oh = '0;
        for (int k = 0; k < N_OUT; k++) begin
            in_oh[k]   = (select     == SEL_W'(k));
            hold_oh[k] = (hold_sel_q == SEL_W'(k));
        end
        in_sel_ok     = |in_oh;
        in_tgt_full   = |(in_oh & full);
        hold_tgt_full = |(hold_oh & full);
    end

    // Next-state logic: route, discard, park, or drain the held word
    always_comb begin
        state_d    = state_q;
        hold_dat_d = hold_dat_q;
        hold_sel_d = hold_sel_q;
        out_d      = out_q;
        push_d     = '0;
        sel_err_d  = 1'b0;
        case (state_q)
            PASS: begin
                if (valid_in) begin
                    if (!in_sel_ok) begin
                        // Nowhere to deliver it: drop and flag.
                        sel_err_d = 1'b1;
                    end else if (!in_tgt_full) begin
                        push_d = in_oh;
                        for (int k = 0; k < N_OUT; k++) begin
                            if (in_oh[k]) begin
                                out_d[k] = in;
                            end
                        end
                    end else begin
                        // Target full: keep the word and stop upstream.
                        hold_dat_d = in;
                        hold_sel_d = select;
                        state_d    = STALL;
                    end
                end
            end
            STALL: begin
                // Upstream is ignored here; only the held target matters.
                if (!hold_tgt_full) begin
                    push_d = hold_oh;
                    for (int k = 0; k < N_OUT; k++) begin
                        if (hold_oh[k]) begin
                            out_d[k] = hold_dat_q;
                        end
                    end
                    state_d = PASS;
                end
            end
            default: begin
                state_d = PASS;
            end
        endcase
    end

    // State, hold register and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= PASS;
            hold_dat_q <= '0;
            hold_sel_q <= '0;
            push_q     <= '0;
            sel_err_q  <= 1'b0;
            for (int k = 0; k < N_OUT; k++) begin
                out_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            hold_dat_q <= hold_dat_d;
            hold_sel_q <= hold_sel_d;
            push_q     <= push_d;
            sel_err_q  <= sel_err_d;
            for (int k = 0; k < N_OUT; k++) begin
                out_q[k] <= out_d[k];
            end
        end
    end

    // ready_in comes from the state flop alone, so it never depends on same-cycle full
    assign ready_in = (state_q == PASS);
    assign push     = push_q;
    assign sel_err  = sel_err_q;

    // Flatten per-channel output data
    always_comb begin
        out = '0;
        for (int k = 0; k < N_OUT; k++) begin
            out[k*DATA_W +: DATA_W] = out_q[k];
        end
    end

`ifdef DEMUX_STATS_EN
    logic [CNT_W-1:0] cnt_q [N_OUT];
    logic [CNT_W-1:0] cnt_d [N_OUT];

    // Saturating per-channel push counters, bumped for each emitted push strobe
    always_comb begin
        for (int k = 0; k < N_OUT; k++) begin
            cnt_d[k] = cnt_q[k];
            if (push_q[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
        end
    end

    // Counter flops, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N_OUT; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    // Flatten counters onto the output bus
    always_comb begin
        push_cnt = '0;
        for (int k = 0; k < N_OUT; k++) begin
            push_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
        end
    end
`else
    assign push_cnt = '0;
`endif

endmodule

// File: tb/tb_demux1xn_fc.sv
// Bench for demux1xn_fc: two instances (N_OUT=4 and N_OUT=3) share stimulus.
// Each instance is compared every cycle against a transaction-level model.
// Stimulus: directed scenarios, then randomized traffic with random resets.
module tb_demux1xn_fc;

    localparam int DW = 10;
    localparam int CW = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  in_d;
    logic        valid_in;
    logic [1:0]  sel;
    logic [3:0]  full;

    logic        ready4, err4;
    logic [39:0] out4;
    logic [3:0]  push4;
    logic [31:0] cnt4;

    logic        ready3, err3;
    logic [29:0] out3;
    logic [2:0]  push3;
    logic [23:0] cnt3;

    always #5 clk = ~clk;

    demux1xn_fc #(.DATA_W(DW), .N_OUT(4), .SEL_W(2), .CNT_W(CW)) dut4 (
        .clk(clk), .reset(reset), .in(in_d), .valid_in(valid_in), .select(sel),
        .full(full), .ready_in(ready4), .out(out4), .push(push4),
        .sel_err(err4), .push_cnt(cnt4)
    );

    demux1xn_fc #(.DATA_W(DW), .N_OUT(3), .SEL_W(2), .CNT_W(CW)) dut3 (
        .clk(clk), .reset(reset), .in(in_d), .valid_in(valid_in), .select(sel),
        .full(full[2:0]), .ready_in(ready3), .out(out3), .push(push3),
        .sel_err(err3), .push_cnt(cnt3)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: per instance, a pending word (if any) plus the
    // expected visible outputs after the most recent clock edge.
    int         m_n [2] = '{4, 3};
    bit         m_busy [2];
    int         m_hsel [2];
    logic [9:0] m_hdat [2];
    logic [9:0] m_out  [2][4];
    int         m_push [2];
    bit         m_err  [2];
    int         m_cnt  [2][4];

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_hsel[i] = 0; m_hdat[i] = '0;
            m_push[i] = 0; m_err[i] = 0;
            for (int k = 0; k < 4; k++) begin
                m_out[i][k] = '0;
                m_cnt[i][k] = 0;
            end
        end
    endfunction

    // Advance the model across one rising edge with the given inputs.
    function automatic void predict(bit v, logic [9:0] d, int s, logic [3:0] f);
        for (int i = 0; i < 2; i++) begin
            int np = 0;
            bit ne = 0;
`ifdef DEMUX_STATS_EN
            for (int k = 0; k < m_n[i]; k++)
                if (((m_push[i] >> k) & 1) == 1 && m_cnt[i][k] < (1 << CW) - 1)
                    m_cnt[i][k]++;
`endif
            if (!m_busy[i]) begin
                if (v) begin
                    if (s >= m_n[i]) ne = 1;
                    else if (f[s] == 1'b0) begin
                        m_out[i][s] = d;
                        np = 1 << s;
                    end else begin
                        m_busy[i] = 1; m_hsel[i] = s; m_hdat[i] = d;
                    end
                end
            end else if (f[m_hsel[i]] == 1'b0) begin
                m_out[i][m_hsel[i]] = m_hdat[i];
                np = 1 << m_hsel[i];
                m_busy[i] = 0;
            end
            m_push[i] = np;
            m_err[i]  = ne;
        end
    endfunction

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            logic        r, e;
            logic [3:0]  p;
            logic [39:0] o;
            logic [31:0] c;
            if (i == 0) begin
                r = ready4; e = err4; p = push4; o = out4; c = cnt4;
            end else begin
                r = ready3; e = err3; p = {1'b0, push3}; o = {10'b0, out3}; c = {8'b0, cnt3};
            end
            check_eq($sformatf("ready%0d", i), 64'(r), 64'(!m_busy[i]));
            check_eq($sformatf("push%0d", i), 64'(p), 64'(m_push[i]));
            check_eq($sformatf("sel_err%0d", i), 64'(e), 64'(m_err[i]));
            for (int k = 0; k < m_n[i]; k++) begin
                check_eq($sformatf("out%0d_ch%0d", i, k), 64'((o >> (k * DW)) & 40'h3FF), 64'(m_out[i][k]));
                check_eq($sformatf("cnt%0d_ch%0d", i, k), 64'((c >> (k * CW)) & 32'hFF), 64'(m_cnt[i][k]));
            end
        end
    endtask

    // One cycle: check outputs of the previous edge, then drive the next inputs.
    task automatic cycle(bit v, logic [9:0] d, logic [1:0] s, logic [3:0] f);
        @(negedge clk);
        check_all();
        valid_in = v; in_d = d; sel = s; full = f;
        predict(v, d, int'(s), f);
    endtask

    task automatic do_reset();
        @(negedge clk);
        check_all();
        reset = 1'b0; valid_in = 1'b0; full = '0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b1;
        predict(1'b0, '0, 0, '0);
    endtask

    initial begin
        reset = 1'b0; valid_in = 1'b0; in_d = '0; sel = '0; full = '0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b1;
        predict(1'b0, '0, 0, '0);

        // Routing to every select, back-to-back
        for (int s = 0; s < 4; s++) cycle(1'b1, 10'h155, 2'(s), 4'b0000);
        cycle(1'b0, '0, 2'd0, 4'b0000);

        // Backpressure on channel 2, held for five cycles
        cycle(1'b1, 10'h2A3, 2'd2, 4'b0100);
        for (int j = 0; j < 5; j++) cycle(1'b1, 10'($urandom), 2'($urandom), 4'b0100);
        cycle(1'b0, '0, 2'd0, 4'b0000);
        cycle(1'b0, '0, 2'd0, 4'b0000);

        // Out-of-range select
        cycle(1'b1, 10'h3FF, 2'd3, 4'b0000);
        cycle(1'b0, '0, 2'd0, 4'b0000);

        // Isolation: channel 1 full must not affect other channels
        cycle(1'b1, 10'h011, 2'd0, 4'b0010);
        cycle(1'b1, 10'h033, 2'd3, 4'b0010);
        cycle(1'b1, 10'h044, 2'd0, 4'b0010);
        cycle(1'b0, '0, 2'd0, 4'b0010);

        // Reset while a word is held
        cycle(1'b1, 10'h1AB, 2'd1, 4'b0010);
        cycle(1'b0, '0, 2'd0, 4'b0010);
        do_reset();
        for (int j = 0; j < 3; j++) cycle(1'b0, '0, 2'd0, 4'b0000);

        // Randomized traffic with occasional resets
        for (int j = 0; j < 600; j++) begin
            logic [3:0] f;
            f = '0;
            for (int k = 0; k < 4; k++) f[k] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 79) == 0) do_reset();
            else cycle(($urandom_range(0, 3) != 0), 10'($urandom), 2'($urandom), f);
        end

        // Long run to one channel (saturates the counters when built in)
        for (int j = 0; j < 300; j++) cycle(1'b1, 10'($urandom), 2'd0, 4'b0000);
        cycle(1'b0, '0, 2'd0, 4'b0000);

        @(negedge clk);
        check_all();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
